// File: rtl/uart_cfg_pkg.sv
`timescale 1ns / 1ps
// Shared encodings and frame helpers for the configurable-frame UART.
package uart_cfg_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // RX FIFO word: {frame_err, parity_err, data[7:0]}
  localparam int unsigned RX_WORD_W    = 10;
  localparam int unsigned RX_FRAME_BIT = 9;
  localparam int unsigned RX_PAR_BIT   = 8;

  function automatic logic [7:0] data_mask(input logic [1:0] dbits);
    case (dbits)
      DBITS_5: data_mask = 8'h1F;
      DBITS_6: data_mask = 8'h3F;
      DBITS_7: data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic parity_on(input logic [1:0] par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] dbits,
                                      input logic [1:0] par);
    return (^(data & data_mask(dbits))) ^ (par == PAR_ODD);
  endfunction

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

  function automatic logic [2:0] last_bit(input logic [1:0] dbits);
    return {1'b0, dbits} + 3'd4;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
`timescale 1ns / 1ps
// Synchronous FIFO with show-ahead head word; pointers carry an extra wrap bit.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o   = (wptr_q == rptr_q);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push_s) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop_s)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_cfg.sv
`timescale 1ns / 1ps
// Configurable-frame UART (5-8 data bits, none/even/odd parity, 1/2 stop bits)
// with FIFO-buffered TX and RX paths.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter bit          TX_ENABLE   = 1'b1,
  parameter bit          RX_ENABLE   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic [1:0]  cfg_data_bits,
  input  logic [1:0]  cfg_parity,
  input  logic        cfg_stop2,
  input  logic        tx_start,
  input  logic [7:0]  tx_data,
  output logic        tx_pin,
  output logic        tx_fifo_full,
  output logic        tx_fifo_empty,
  output logic        tx_busy,
  input  logic        rx_pin,
  input  logic        rx_read,
  output logic        rx_ready,
  output logic [7:0]  rx_byte,
  output logic        rx_err_parity,
  output logic        rx_err_frame,
  output logic        rx_overrun,
  input  logic        rx_err_clear
);

  if (TX_ENABLE) begin : g_tx
    tx_state_e   state_q;
    logic [15:0] cnt_q;
    logic [15:0] div_q;
    logic [2:0]  bit_q;
    logic [7:0]  data_q;
    logic [1:0]  dbits_q;
    logic [1:0]  par_q;
    logic        stop2_q;
    logic        pin_q;
    logic        busy_q;
    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic [7:0]  head_s;
    logic        bit_end_s;
    logic        frame_end_s;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_start),
      .pop_i   (pop_s),
      .wdata_i (tx_data),
      .rdata_o (head_s),
      .full_o  (full_s),
      .empty_o (empty_s)
    );

    assign bit_end_s   = (cnt_q == 16'd0);
    assign frame_end_s = (state_q == TX_STOP) && bit_end_s && (!stop2_q || bit_q[0]);
    assign pop_s       = !empty_s && ((state_q == TX_IDLE) || frame_end_s);

    // Pin and busy follow the state one clock later, so every bit still lasts div_q clocks.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= TX_IDLE;
        cnt_q   <= 16'd0;
        div_q   <= 16'd2;
        bit_q   <= 3'd0;
        data_q  <= 8'd0;
        dbits_q <= DBITS_8;
        par_q   <= PAR_NONE;
        stop2_q <= 1'b0;
        pin_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        busy_q <= (state_q != TX_IDLE);
        case (state_q)
          TX_START:  pin_q <= 1'b0;
          TX_DATA:   pin_q <= data_q[bit_q];
          TX_PARITY: pin_q <= parity_bit(data_q, dbits_q, par_q);
          default:   pin_q <= 1'b1;
        endcase
        if (pop_s) begin
          state_q <= TX_START;
          div_q   <= eff_div(baud_div);
          cnt_q   <= eff_div(baud_div) - 16'd1;
          bit_q   <= 3'd0;
          data_q  <= head_s & data_mask(cfg_data_bits);
          dbits_q <= cfg_data_bits;
          par_q   <= cfg_parity;
          stop2_q <= cfg_stop2;
        end else begin
          case (state_q)
            TX_IDLE: state_q <= TX_IDLE;
            TX_START: begin
              if (!bit_end_s) cnt_q <= cnt_q - 16'd1;
              else begin
                state_q <= TX_DATA;
                cnt_q   <= div_q - 16'd1;
                bit_q   <= 3'd0;
              end
            end
            TX_DATA: begin
              if (!bit_end_s) cnt_q <= cnt_q - 16'd1;
              else begin
                cnt_q <= div_q - 16'd1;
                if (bit_q == last_bit(dbits_q)) begin
                  state_q <= parity_on(par_q) ? TX_PARITY : TX_STOP;
                  bit_q   <= 3'd0;
                end else begin
                  bit_q <= bit_q + 3'd1;
                end
              end
            end
            TX_PARITY: begin
              if (!bit_end_s) cnt_q <= cnt_q - 16'd1;
              else begin
                state_q <= TX_STOP;
                cnt_q   <= div_q - 16'd1;
                bit_q   <= 3'd0;
              end
            end
            TX_STOP: begin
              if (!bit_end_s) cnt_q <= cnt_q - 16'd1;
              else if (frame_end_s) state_q <= TX_IDLE;
              else begin
                bit_q <= 3'd1;
                cnt_q <= div_q - 16'd1;
              end
            end
            default: state_q <= TX_IDLE;
          endcase
        end
      end
    end

    assign tx_pin        = pin_q;
    assign tx_busy       = busy_q;
    assign tx_fifo_full  = full_s;
    assign tx_fifo_empty = empty_s;
  end else begin : g_tx_off
    assign tx_pin        = 1'b1;
    assign tx_busy       = 1'b0;
    assign tx_fifo_full  = 1'b0;
    assign tx_fifo_empty = 1'b1;
  end

  if (RX_ENABLE) begin : g_rx
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    rx_state_e              state_q;
    logic [15:0]            cnt_q;
    logic [15:0]            div_q;
    logic [2:0]             bit_q;
    logic [7:0]             data_q;
    logic [1:0]             dbits_q;
    logic [1:0]             par_q;
    logic                   par_err_q;
    logic                   pend_q;
    logic [RX_WORD_W-1:0]   pend_word_q;
    logic [7:0]             byte_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   ovr_q;
    logic                   line_s;
    logic                   fall_s;
    logic                   sample_s;
    logic                   empty_s;
    logic                   full_s;
    logic                   pop_s;
    logic [RX_WORD_W-1:0]   head_s;

    uart_fifo #(.WIDTH(RX_WORD_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (pend_q),
      .pop_i   (pop_s),
      .wdata_i (pend_word_q),
      .rdata_o (head_s),
      .full_o  (full_s),
      .empty_o (empty_s)
    );

    assign line_s   = sync_q[SYNC_STAGES-1];
    assign fall_s   = prev_q && !line_s;
    assign sample_s = (cnt_q == 16'd0);
    assign pop_s    = rx_read && !empty_s;

    // Metastability chain on the asynchronous pin, idle high.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '1;
        prev_q <= 1'b1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
        prev_q <= line_s;
      end
    end

    // Completed frames are staged one clock so rx_ready rises the edge after the stop sample.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q     <= RX_IDLE;
        cnt_q       <= 16'd0;
        div_q       <= 16'd2;
        bit_q       <= 3'd0;
        data_q      <= 8'd0;
        dbits_q     <= DBITS_8;
        par_q       <= PAR_NONE;
        par_err_q   <= 1'b0;
        pend_q      <= 1'b0;
        pend_word_q <= '0;
      end else begin
        pend_q <= 1'b0;
        case (state_q)
          RX_IDLE: begin
            if (fall_s) begin
              state_q   <= RX_START;
              div_q     <= eff_div(baud_div);
              cnt_q     <= (eff_div(baud_div) >> 3'd1) - 16'd1;
              dbits_q   <= cfg_data_bits;
              par_q     <= cfg_parity;
              data_q    <= 8'd0;
              par_err_q <= 1'b0;
              bit_q     <= 3'd0;
            end
          end
          RX_START: begin
            if (!sample_s) cnt_q <= cnt_q - 16'd1;
            else if (line_s) state_q <= RX_IDLE;
            else begin
              state_q <= RX_DATA;
              cnt_q   <= div_q - 16'd1;
            end
          end
          RX_DATA: begin
            if (!sample_s) cnt_q <= cnt_q - 16'd1;
            else begin
              data_q[bit_q] <= line_s;
              cnt_q         <= div_q - 16'd1;
              if (bit_q == last_bit(dbits_q)) begin
                state_q <= parity_on(par_q) ? RX_PARITY : RX_STOP;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end
          end
          RX_PARITY: begin
            if (!sample_s) cnt_q <= cnt_q - 16'd1;
            else begin
              par_err_q <= (line_s != parity_bit(data_q, dbits_q, par_q));
              state_q   <= RX_STOP;
              cnt_q     <= div_q - 16'd1;
            end
          end
          RX_STOP: begin
            if (!sample_s) cnt_q <= cnt_q - 16'd1;
            else begin
              pend_q      <= 1'b1;
              pend_word_q <= {~line_s, par_err_q, data_q};
              state_q     <= RX_IDLE;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end

    // Host-side view of the last popped word and the sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        byte_q <= 8'd0;
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (pop_s) begin
          byte_q <= head_s[7:0];
          perr_q <= head_s[RX_PAR_BIT];
          ferr_q <= head_s[RX_FRAME_BIT];
        end
        if (pend_q && full_s) ovr_q <= 1'b1;
        else if (rx_err_clear) ovr_q <= 1'b0;
      end
    end

    assign rx_ready      = !empty_s;
    assign rx_byte       = byte_q;
    assign rx_err_parity = perr_q;
    assign rx_err_frame  = ferr_q;
    assign rx_overrun    = ovr_q;
  end else begin : g_rx_off
    assign rx_ready      = 1'b0;
    assign rx_byte       = 8'd0;
    assign rx_err_parity = 1'b0;
    assign rx_err_frame  = 1'b0;
    assign rx_overrun    = 1'b0;
  end

endmodule

// File: tb/tb_uart_cfg.sv
`timescale 1ns / 1ps
// Self-checking bench for uart_cfg: random frames checked against a bit-level line model.
module tb_uart_cfg;

  localparam int DIV   = 16;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_pin;
  logic        tx_fifo_full;
  logic        tx_fifo_empty;
  logic        tx_busy;
  logic        rx_pin;
  logic        rx_read;
  logic        rx_ready;
  logic [7:0]  rx_byte;
  logic        rx_err_parity;
  logic        rx_err_frame;
  logic        rx_overrun;
  logic        rx_err_clear;
  logic        loop_en;
  logic        ext_pin;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  assign rx_pin = loop_en ? tx_pin : ext_pin;

  uart_cfg #(.FIFO_DEPTH(DEPTH), .TX_ENABLE(1'b1), .RX_ENABLE(1'b1), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_div      (baud_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_pin        (tx_pin),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_busy       (tx_busy),
    .rx_pin        (rx_pin),
    .rx_read       (rx_read),
    .rx_ready      (rx_ready),
    .rx_byte       (rx_byte),
    .rx_err_parity (rx_err_parity),
    .rx_err_frame  (rx_err_frame),
    .rx_overrun    (rx_overrun),
    .rx_err_clear  (rx_err_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] d, input int nbits);
    int m;
    m = (1 << nbits) - 1;
    return d & m[7:0];
  endfunction

  function automatic bit exp_parity(input logic [7:0] d, input int nbits, input bit odd);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(d[i]);
    return ones[0] ^ odd;
  endfunction

  task automatic set_cfg(input int nbits, input int par, input bit s2);
    cfg_data_bits = 2'(nbits - 5);
    cfg_parity    = 2'(par);
    cfg_stop2     = s2;
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic do_read();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic wait_ready(input int limit, input string tag);
    int t = 0;
    while (rx_ready !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_ready"}, rx_ready, 1'b1);
  endtask

  // Expected line waveform is built from the frame rules, then sampled mid-bit.
  task automatic watch_frame(input logic [7:0] d, input int nbits, input int par, input bit s2,
                             input string tag);
    bit exp_q[$];
    int t = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) exp_q.push_back(d[i]);
    if (par == 1) exp_q.push_back(exp_parity(d, nbits, 1'b0));
    else if (par == 2) exp_q.push_back(exp_parity(d, nbits, 1'b1));
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
    while (tx_pin !== 1'b0 && t < 4 * DIV) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_start"}, tx_pin, 1'b0);
    for (int k = 0; k < exp_q.size() * DIV; k++) begin
      if (k % DIV == DIV / 2) check({tag, "_bit"}, tx_pin, exp_q[k / DIV]);
      if (k == exp_q.size() * DIV - 1) check({tag, "_busy_end"}, tx_busy, 1'b1);
      @(negedge clk);
    end
    check({tag, "_idle_after"}, tx_busy, 1'b0);
  endtask

  task automatic drive_bit(input bit b);
    ext_pin = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_ext(input logic [7:0] d, input int nbits, input bit has_par,
                          input bit par_val, input bit stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par_val);
    drive_bit(stop_val);
    ext_pin = 1'b1;
  endtask

  initial begin
    logic [7:0] sent_q[$];
    logic [7:0] d;
    int nb;
    int par;
    bit s2;
    int busy_n;
    int t;
    bit wrong_par;

    rst = 1'b1;
    baud_div = 16'(DIV);
    set_cfg(8, 0, 1'b0);
    tx_start = 1'b0;
    tx_data = 8'h00;
    rx_read = 1'b0;
    rx_err_clear = 1'b0;
    loop_en = 1'b1;
    ext_pin = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_tx_pin", tx_pin, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_empty", tx_fifo_empty, 1'b1);
    check("rst_tx_full", tx_fifo_full, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_err_flags", {rx_err_parity, rx_err_frame, rx_overrun}, 3'b000);

    // 8N1 0xAA with start-bit latency relative to the push edge
    push_tx(8'hAA);
    check("push_flag_empty", tx_fifo_empty, 1'b0);
    check("lat_n0_pin", tx_pin, 1'b1);
    @(negedge clk);
    check("lat_n1_pin", tx_pin, 1'b1);
    @(negedge clk);
    check("lat_n2_pin", tx_pin, 1'b0);
    watch_frame(8'hAA, 8, 0, 1'b0, "f8n1");
    wait_ready(4 * DIV, "f8n1");
    do_read();
    check("f8n1_byte", rx_byte, 8'hAA);
    check("f8n1_errs", {rx_err_parity, rx_err_frame}, 2'b00);
    check("f8n1_ready_low", rx_ready, 1'b0);

    set_cfg(7, 1, 1'b1);
    push_tx(8'hFF);
    watch_frame(8'hFF, 7, 1, 1'b1, "f7e2");
    wait_ready(4 * DIV, "f7e2");
    do_read();
    check("f7e2_byte", rx_byte, 8'h7F);
    check("f7e2_errs", {rx_err_parity, rx_err_frame}, 2'b00);

    for (int it = 0; it < 10; it++) begin
      nb  = int'($urandom_range(8, 5));
      par = int'($urandom_range(3, 0));
      s2  = 1'($urandom_range(1, 0));
      d   = 8'($urandom);
      set_cfg(nb, par, s2);
      push_tx(d);
      watch_frame(d, nb, (par == 3) ? 0 : par, s2, "rand");
      wait_ready(4 * DIV, "rand");
      do_read();
      check("rand_byte", rx_byte, exp_byte(d, nb));
      check("rand_errs", {rx_err_parity, rx_err_frame}, 2'b00);
    end

    // External 8E1 frame carrying the wrong parity bit
    loop_en = 1'b0;
    set_cfg(8, 1, 1'b0);
    wrong_par = ~exp_parity(8'h01, 8, 1'b0);
    send_ext(8'h01, 8, 1'b1, wrong_par, 1'b1);
    wait_ready(4 * DIV, "ext_par");
    do_read();
    check("ext_par_byte", rx_byte, 8'h01);
    check("ext_par_perr", rx_err_parity, 1'b1);
    check("ext_par_ferr", rx_err_frame, 1'b0);

    set_cfg(8, 0, 1'b0);
    send_ext(8'h5A, 8, 1'b0, 1'b0, 1'b0);
    wait_ready(4 * DIV, "ext_frm");
    do_read();
    check("ext_frm_byte", rx_byte, 8'h5A);
    check("ext_frm_ferr", rx_err_frame, 1'b1);
    check("ext_frm_perr", rx_err_parity, 1'b0);

    repeat (2 * DIV) @(negedge clk);
    ext_pin = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    ext_pin = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("glitch_no_push", rx_ready, 1'b0);
    do_read();
    check("empty_read_holds", rx_byte, 8'h5A);

    // Burst: one frame in flight plus a full TX FIFO, then one rejected push
    loop_en = 1'b1;
    d = 8'($urandom);
    sent_q.push_back(d);
    push_tx(d);
    t = 0;
    while (tx_busy !== 1'b1 && t < 4 * DIV) begin
      @(negedge clk);
      t++;
    end
    check("burst_busy", tx_busy, 1'b1);
    busy_n = 1;
    tx_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      sent_q.push_back(d);
      tx_data = d;
      @(negedge clk);
      if (tx_busy) busy_n++;
    end
    tx_start = 1'b0;
    check("burst_full", tx_fifo_full, 1'b1);
    push_tx(8'($urandom));
    if (tx_busy) busy_n++;
    check("burst_full_after_drop", tx_fifo_full, 1'b1);
    t = 0;
    while (tx_busy === 1'b1 && t < (DEPTH + 3) * 10 * DIV) begin
      @(negedge clk);
      if (tx_busy) busy_n++;
      t++;
    end
    check("burst_busy_clocks", busy_n, (DEPTH + 1) * 10 * DIV);
    repeat (DIV) @(negedge clk);
    check("burst_overrun", rx_overrun, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      do_read();
      check("burst_byte", rx_byte, sent_q[i]);
    end
    check("burst_rx_drained", rx_ready, 1'b0);
    rx_err_clear = 1'b1;
    @(negedge clk);
    rx_err_clear = 1'b0;
    check("overrun_cleared", rx_overrun, 1'b0);

    push_tx(8'h55);
    t = 0;
    while (tx_pin !== 1'b0 && t < 4 * DIV) begin
      @(negedge clk);
      t++;
    end
    repeat (DIV + 3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_tx_pin", tx_pin, 1'b1);
    check("midrst_tx_busy", tx_busy, 1'b0);
    check("midrst_tx_empty", tx_fifo_empty, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
